// File: rtl/text_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// text_scroll_ctrl
//   Scrolling-message scheduler for a 7-segment character table. The table
//   maps an index to a pattern and has a registered latency of one cycle.
//   One table instance is shared across all digits. Each frame issues one
//   lookup per cycle and collects the patterns into a shadow frame. The
//   whole frame is then committed atomically to seg_out. The scroll offset
//   advances once every TICK_DIV enabled clocks.
//
//   The message is viewed as a virtual sequence of L = len + NUM_DIGITS
//   positions, where len = min(msg_len, MSG_DEPTH). Positions at or beyond
//   len map to index 0 (blank). Digit d shows position (offset + d) mod L.
//
// Ports
//   clk, rst_n   clock; synchronous active-low reset
//   en           scroll enable (its rising edge also requests a frame)
//   restart      pulse: offset and tick counter cleared, new frame at once
//   wr_en/wr_addr/wr_data   message buffer write port
//   msg_len      active message length (clamped to MSG_DEPTH)
//   dir          (TEXT_SCROLL_DIR_EN only) 0 = scroll left, 1 = scroll right
//   tbl_index    registered lookup index to the character table
//   tbl_text     table pattern, valid one cycle after tbl_index
//   seg_out      committed frame; digit d at [7d+6:7d]; active-low segments
//   busy         frame fetch in progress
//   frame_done   one-cycle pulse when seg_out updates
//
// Build option: define TEXT_SCROLL_DIR_EN to add the dir input.
// ---------------------------------------------------------------------------
module text_scroll_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int MSG_DEPTH  = 32,
  parameter int TICK_DIV   = 25000000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           restart,
  input  logic                           wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0]   wr_addr,
  input  logic [6:0]                     wr_data,
  input  logic [$clog2(MSG_DEPTH):0]     msg_len,
`ifdef TEXT_SCROLL_DIR_EN
  input  logic                           dir,
`endif
  output logic [6:0]                     tbl_index,
  input  logic [6:0]                     tbl_text,
  output logic [7*NUM_DIGITS-1:0]        seg_out,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int PW = $clog2(MSG_DEPTH + NUM_DIGITS + 1);  // holds L itself
  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(NUM_DIGITS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [6:0]              msg_mem [MSG_DEPTH];
  logic [1:0]              state;
  logic [CW-1:0]           dig_cnt;   // FETCH: digits issued; DRAIN: cycles spent
  logic [CW-1:0]           cap_ptr;   // next shadow slot to capture
  logic                    iss_v;     // a lookup was issued on the last edge
  logic                    cap_v;     // tbl_text currently holds a frame pattern
  logic [PW-1:0]           offset;
  logic [PW-1:0]           pos;       // wrapping position pointer for the frame
  logic [PW-1:0]           vlen_r;    // L sampled at frame start
  logic [AW:0]             len_r;     // len sampled at frame start
  logic [TW-1:0]           tick_cnt;
  logic                    pending;
  logic                    en_q;
  logic [7*NUM_DIGITS-1:0] shadow;

  logic [AW:0]   len_now;
  logic [PW-1:0] vlen_now;
  logic          tick;
  logic          trigger;
  logic          start;
  logic [PW-1:0] off_step;
  logic [PW-1:0] off_start;
  logic [PW-1:0] fetch_pos;
  logic [AW:0]   fetch_len;
  logic [PW-1:0] fetch_vlen;
  logic [6:0]    fetch_char;
  logic [PW-1:0] next_pos;

  // NOTE: message storage has no reset so it can map onto plain RAM; its
  // contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (wr_en) msg_mem[wr_addr] <= wr_data;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    len_now    = '0;
    vlen_now   = '0;
    tick       = 1'b0;
    trigger    = 1'b0;
    start      = 1'b0;
    off_step   = '0;
    off_start  = '0;
    fetch_pos  = '0;
    fetch_len  = '0;
    fetch_vlen = '0;
    fetch_char = '0;
    next_pos   = '0;

    len_now  = (msg_len > (AW+1)'(MSG_DEPTH)) ? (AW+1)'(MSG_DEPTH) : msg_len;
    vlen_now = PW'(len_now) + PW'(NUM_DIGITS);
    tick     = en && (tick_cnt == TW'(TICK_DIV - 1));
    // New frames need en; restart always starts one.
    trigger  = (state == S_IDLE) && en && (tick || pending || !en_q);
    start    = restart || trigger;

`ifdef TEXT_SCROLL_DIR_EN
    if (dir)
      off_step = (offset == '0 || offset >= vlen_now) ? vlen_now - PW'(1)
                                                      : offset - PW'(1);
    else
      off_step = (offset >= vlen_now - PW'(1)) ? '0 : offset + PW'(1);
`else
    off_step = (offset >= vlen_now - PW'(1)) ? '0 : offset + PW'(1);
`endif

    // The offset moves before the frame for that tick is fetched.
    if (restart)               off_start = '0;
    else if (tick || pending)  off_start = off_step;
    else                       off_start = offset;

    // At frame start the pointer begins at the new offset and uses the live
    // length. Later in the frame it uses the lengths latched at the start.
    if (start) begin
      fetch_pos  = (off_start >= vlen_now) ? '0 : off_start;
      fetch_len  = len_now;
      fetch_vlen = vlen_now;
    end else begin
      fetch_pos  = pos;
      fetch_len  = len_r;
      fetch_vlen = vlen_r;
    end
    fetch_char = (fetch_pos < PW'(fetch_len)) ? msg_mem[fetch_pos[AW-1:0]] : 7'd0;
    next_pos   = (fetch_pos >= fetch_vlen - PW'(1)) ? '0 : fetch_pos + PW'(1);
  end

  // NOTE: all state below uses non-blocking assignments, so every read in
  // this block sees the pre-edge value no matter the statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      dig_cnt    <= '0;
      cap_ptr    <= '0;
      iss_v      <= 1'b0;
      cap_v      <= 1'b0;
      offset     <= '0;
      pos        <= '0;
      vlen_r     <= '0;
      len_r      <= '0;
      tick_cnt   <= '0;
      pending    <= 1'b0;
      en_q       <= 1'b0;
      shadow     <= '1;
      seg_out    <= '1;
      tbl_index  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      en_q       <= en;
      iss_v      <= 1'b0;
      cap_v      <= iss_v;

      if (restart || !en || tick) tick_cnt <= '0;
      else                        tick_cnt <= tick_cnt + TW'(1);

      // At most one tick waits while a frame is in flight.
      if (restart)                       pending <= 1'b0;
      else if (trigger)                  pending <= pending && tick;
      else if (!en)                      pending <= 1'b0;
      else if (tick)                     pending <= 1'b1;

      // Pattern for the lookup issued two edges ago.
      if (cap_v) begin
        shadow[7*cap_ptr +: 7] <= tbl_text;
        cap_ptr                <= cap_ptr + CW'(1);
      end

      if (start) begin
        offset    <= off_start;
        len_r     <= len_now;
        vlen_r    <= vlen_now;
        tbl_index <= fetch_char;
        pos       <= next_pos;
        iss_v     <= 1'b1;
        dig_cnt   <= CW'(1);
        cap_ptr   <= '0;
        busy      <= 1'b1;
        state     <= S_FETCH;
        if (restart) begin
          // Abort: drop in-flight captures; seg_out keeps the last frame.
          cap_v  <= 1'b0;
          shadow <= '1;
        end
      end else begin
        case (state)
          S_FETCH: begin
            tbl_index <= fetch_char;
            pos       <= next_pos;
            iss_v     <= 1'b1;
            dig_cnt   <= dig_cnt + CW'(1);
            if (dig_cnt == CW'(NUM_DIGITS - 1)) begin
              dig_cnt <= '0;
              state   <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (dig_cnt == '0) dig_cnt <= CW'(1);
            else               state   <= S_COMMIT;
          end
          S_COMMIT: begin
            seg_out    <= shadow;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/text_scroll_ctrl.md
Name: text_scroll_ctrl

Overview:
- Scrolling-message scheduler for the 7-segment character table (index-to-pattern lookup, 1-cycle registered latency).
- Holds a message of character indices and time-shares one table instance across NUM_DIGITS digits.
- Issues one lookup per cycle, collects the patterns into a shadow frame, then commits the whole frame atomically to the digit drivers.
- Advances the scroll offset every TICK_DIV clocks.

Parameters:
- NUM_DIGITS, 8, number of 7-seg digits driven; must be >= 2.
- MSG_DEPTH, 32, message buffer entries; power of 2.
- TICK_DIV, 25000000, clk cycles per scroll step; must be >= NUM_DIGITS+4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  scroll enable.
- restart  in  1  pulse: offset<=0, tick counter cleared, immediate frame.
- wr_en  in  1  message write strobe.
- wr_addr  in  log2(MSG_DEPTH)  message write address.
- wr_data  in  7  character index to store.
- msg_len  in  log2(MSG_DEPTH)+1  active message length.
- tbl_index  out  7  registered index to table lookup.
- tbl_text  in  7  table pattern, valid 1 cycle after tbl_index.
- seg_out  out  7*NUM_DIGITS  committed frame; digit d (0 = leftmost) at [7d+6:7d]; active-low segments.
- busy  out  1  frame fetch in progress.
- frame_done  out  1  one-cycle pulse when seg_out updates.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values:
  - seg_out all 1s (blank); tbl_index 0; busy 0; frame_done 0.
  - Offset 0; tick counter 0; state IDLE; shadow all 1s.
  - Message buffer contents are not reset.
- Message writes:
  - Accepted in any state; take effect on the next edge.
  - There is no frame-consistency protection for writes.
- Virtual sequence:
  - L = len + NUM_DIGITS, where len = min(msg_len, MSG_DEPTH), sampled at frame start.
  - Position p maps to char p = msg[p] if p < len, else index 0 (blank).
- Digit index: digit d shows position (offset+d) mod L. Compute this with a wrapping pointer (increment, compare to L-1, reset to 0); no divider.
- Tick counter:
  - Counts 0..TICK_DIV-1 while en=1.
  - Holds at 0 while en=0.
  - Wrap produces a tick.
- Tick handling: a tick that arrives while busy is latched (one pending max) and serviced on return to IDLE.
- Offset: advances by 1 mod L at each tick, before that tick's frame is fetched.
- States:
  - IDLE: frame trigger is a tick, a pending tick, restart, or en rising → FETCH.
  - FETCH: N cycles; tbl_index loaded with digit 0..N-1 chars on successive edges.
  - DRAIN: 2 cycles; last captures.
  - COMMIT: 1 cycle; shadow → seg_out, frame_done=1; → IDLE.
- Frame timing:
  - Trigger edge E0 loads digit 0's index.
  - Shadow[k] captures tbl_text at edge E(k+2).
  - seg_out updates and frame_done asserts at edge E(N+2) for exactly one cycle.
  - busy is high from E0 through E(N+1).
- Restart precedence: restart in any state aborts the frame (shadow discarded, seg_out held) and starts a new frame at offset 0. It has priority over tick.
- en=0 mid-frame: the current frame completes and commits; no new frames start; seg_out holds.
- msg_len=0: L=NUM_DIGITS; all digits index 0 → blank frame.
- msg_len > MSG_DEPTH: clamped to MSG_DEPTH.
- rst_n low mid-frame: all reset values apply at that edge; no frame_done is emitted.
- Index handling: indices pass through unchecked; the table maps out-of-range indices to blank. Two-digit glyphs (M, W) are stored as consecutive left/right indices.

Optional Feature:
- Macro: TEXT_SCROLL_DIR_EN.
- Defined:
  - Adds input dir (1 bit), sampled at each tick.
  - dir=0: offset+1 mod L.
  - dir=1: offset-1, wrapping 0 → L-1.
- Not defined: port absent; left scroll only.

Test Plan:
Bench uses NUM_DIGITS=4, MSG_DEPTH=8, TICK_DIV=16 and a real table instance.
1. Reset: hold rst_n=0 for 3 cycles → seg_out=28'hFFFFFFF, busy=0, frame_done=0, tbl_index=0.
2. Write H,E,L,L,O = 19,16,24,24,27, msg_len=5, restart pulse →
   - tbl_index sequence 19,16,24,24 on consecutive cycles;
   - frame_done 6 edges after trigger;
   - seg_out d0..d3 = 0010010, 0001100, 1011100, 1011100.
3. Same message, en=1:
   - after 1 tick d0..d3 = E,L,L,O;
   - after 4 ticks O,blank,blank,blank;
   - after 9 ticks wraps to H,E,L,L.
4. msg_len=0, en=1 → every frame_done shows seg_out all 1s. msg_len=12 → behaves as len=8 (wraps after 12 ticks).
5. Abort cases:
   - restart asserted at E2 of a frame → prior seg_out held; new frame at offset 0 commits 6 edges later.
   - rst_n=0 at E3 → seg_out blank, no frame_done.
6. With TEXT_SCROLL_DIR_EN, HELLO at offset 0, dir=1, one tick → offset=8, seg_out = blank,H,E,L.
